// File: rtl/game_pkg.sv
// Package game_pkg: shared types, constants and the 7-segment decoder used by
// the tug-of-war match controller.
//   mc_state_t   : match controller state encoding
//   winner_t     : match winner encoding (00 none, 01 left, 10 right)
//   SEG_BLANK    : active-low segment pattern for a dark digit
//   seg7_decode  : 4-bit value -> active-low 7-seg pattern (0-9, else blank)
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    HOLD,
    WAIT,
    MATCH_OVER
  } mc_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10
  } winner_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7_decode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Interface match_controller_if: round/score bus between the match controller
// and its environment (playfield, winner logic, HEX displays).
//   start, left_win, right_win      : inputs to the controller
//   round_reset, left_score,
//   right_score, hex_left,
//   hex_right, match_over, winner   : outputs of the controller
// Modports: slave = controller side, master = environment side.
interface match_controller_if;
  logic       start;
  logic       left_win;
  logic       right_win;
  logic       round_reset;
  logic [3:0] left_score;
  logic [3:0] right_score;
  logic [6:0] hex_left;
  logic [6:0] hex_right;
  logic       match_over;
  logic [1:0] winner;

  modport slave (
    input  start, left_win, right_win,
    output round_reset, left_score, right_score, hex_left, hex_right,
           match_over, winner
  );

  modport master (
    output start, left_win, right_win,
    input  round_reset, left_score, right_score, hex_left, hex_right,
           match_over, winner
  );
endinterface

// File: rtl/seg7_digit.sv
// Module seg7_digit: combinational active-low 7-segment decode of one digit.
//   i_value [3:0] : binary value (0-9 shown, anything else blank)
//   o_seg   [6:0] : active-low segment pattern
module seg7_digit
  import game_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);
  always_comb o_seg = seg7_decode(i_value);
endmodule

// File: rtl/match_controller.sv
// Module match_controller: sequences tug-of-war rounds, keeps per-player scores,
// holds the playfield in reset between rounds and declares the match winner.
//   clk    : system clock, all state on posedge
//   reset  : synchronous, active-high, clears all state
//   bus    : match_controller_if.slave (start/win inputs, round_reset, scores,
//            hex digits, match_over, winner outputs)
// Parameters: WIN_SCORE (1..9), HOLD_CYCLES (>=1).
// Macro AUTO_NEXT_ROUND_EN: when defined, the end of HOLD goes straight back to
// PLAY; when undefined, HOLD ends in WAIT and the next round needs start.
module match_controller
  import game_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  match_controller_if.slave bus
);

  localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [3:0]      WIN_VAL   = 4'(WIN_SCORE);

  mc_state_t     r_state,  w_state_next;
  logic [3:0]    r_left,   w_left_next;
  logic [3:0]    r_right,  w_right_next;
  winner_t       r_winner, w_winner_next;
  logic [CW-1:0] r_cnt,    w_cnt_next;
  logic          r_round_reset;
  logic          r_match_over;
  logic [6:0]    w_hex_left;
  logic [6:0]    w_hex_right;

  // round_reset and match_over are registered from the next state so they
  // change on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_left        <= '0;
      r_right       <= '0;
      r_winner      <= NONE;
      r_cnt         <= '0;
      r_round_reset <= 1'b1;
      r_match_over  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_left        <= w_left_next;
      r_right       <= w_right_next;
      r_winner      <= w_winner_next;
      r_cnt         <= w_cnt_next;
      r_round_reset <= (w_state_next != PLAY);
      r_match_over  <= (w_state_next == MATCH_OVER);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_left_next   = r_left;
    w_right_next  = r_right;
    w_winner_next = r_winner;
    w_cnt_next    = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_next = PLAY;
      end
      PLAY: begin
        // Exactly one side must win; a tie or no result keeps the round going.
        if (bus.left_win ^ bus.right_win) begin
          if (bus.left_win) begin
            w_left_next = r_left + 4'd1;
            if (w_left_next == WIN_VAL) begin
              w_state_next  = MATCH_OVER;
              w_winner_next = LEFT;
            end else begin
              w_state_next = HOLD;
              w_cnt_next   = HOLD_LOAD;
            end
          end else begin
            w_right_next = r_right + 4'd1;
            if (w_right_next == WIN_VAL) begin
              w_state_next  = MATCH_OVER;
              w_winner_next = RIGHT;
            end else begin
              w_state_next = HOLD;
              w_cnt_next   = HOLD_LOAD;
            end
          end
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
`ifdef AUTO_NEXT_ROUND_EN
          w_state_next = PLAY;
`else
          w_state_next = WAIT;
`endif
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
`ifndef AUTO_NEXT_ROUND_EN
      WAIT: begin
        if (bus.start) w_state_next = PLAY;
      end
`endif
      MATCH_OVER: begin
        if (bus.start) begin
          w_state_next  = IDLE;
          w_left_next   = '0;
          w_right_next  = '0;
          w_winner_next = NONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  seg7_digit u_hex_left  (.i_value(r_left),  .o_seg(w_hex_left));
  seg7_digit u_hex_right (.i_value(r_right), .o_seg(w_hex_right));

  assign bus.round_reset = r_round_reset;
  assign bus.left_score  = r_left;
  assign bus.right_score = r_right;
  assign bus.hex_left    = w_hex_left;
  assign bus.hex_right   = w_hex_right;
  assign bus.match_over  = r_match_over;
  assign bus.winner      = r_winner;

endmodule

// File: tb/tb_match_controller.sv
// Testbench tb_match_controller: directed checks of match_controller with
// WIN_SCORE=3, HOLD_CYCLES=4. Inputs change 1 time unit after posedge and
// outputs are checked at that same point, well away from the next edge.
module tb_match_controller;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  match_controller_if bus ();

  match_controller #(.WIN_SCORE(3), .HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Finish the hold after a non-final round win and get back into PLAY.
  task automatic leave_hold();
    for (int unsigned i = 0; i < 4; i++) tick();
`ifndef AUTO_NEXT_ROUND_EN
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
`endif
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.left_win  = 1'b0;
    bus.right_win = 1'b0;
    for (int unsigned i = 0; i < 3; i++) tick();
    reset = 1'b0;

    chk("rst_rr",     32'(bus.round_reset), 32'd1);
    chk("rst_left",   32'(bus.left_score),  32'd0);
    chk("rst_right",  32'(bus.right_score), 32'd0);
    chk("rst_hexl",   32'(bus.hex_left),    32'h40);
    chk("rst_hexr",   32'(bus.hex_right),   32'h40);
    chk("rst_winner", 32'(bus.winner),      32'd0);
    chk("rst_mo",     32'(bus.match_over),  32'd0);

    tick();
    chk("idle_rr", 32'(bus.round_reset), 32'd1);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("play_rr", 32'(bus.round_reset), 32'd0);

    // Tie: no score change, stays in PLAY.
    bus.left_win  = 1'b1;
    bus.right_win = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("tie_rr",    32'(bus.round_reset), 32'd0);
      chk("tie_left",  32'(bus.left_score),  32'd0);
      chk("tie_right", 32'(bus.right_score), 32'd0);
    end
    bus.left_win  = 1'b0;
    bus.right_win = 1'b0;
    tick();
    chk("none_rr", 32'(bus.round_reset), 32'd0);

    // Left wins round 1.
    bus.left_win = 1'b1;
    tick();
    bus.left_win = 1'b0;
    chk("l1_score", 32'(bus.left_score),  32'd1);
    chk("l1_hex",   32'(bus.hex_left),    32'h79);
    chk("l1_rr",    32'(bus.round_reset), 32'd1);

    // Wins and start ignored while holding.
    bus.left_win = 1'b1;
    bus.start    = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("hold_rr",   32'(bus.round_reset), 32'd1);
      chk("hold_left", 32'(bus.left_score),  32'd1);
    end
    bus.left_win = 1'b0;
    bus.start    = 1'b0;
    tick();
`ifdef AUTO_NEXT_ROUND_EN
    chk("after_hold_rr", 32'(bus.round_reset), 32'd0);
`else
    chk("after_hold_rr", 32'(bus.round_reset), 32'd1);
    bus.left_win = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      tick();
      chk("wait_rr",   32'(bus.round_reset), 32'd1);
      chk("wait_left", 32'(bus.left_score),  32'd1);
    end
    bus.left_win = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("wait_start_rr", 32'(bus.round_reset), 32'd0);
`endif

    // Right wins three rounds.
    bus.right_win = 1'b1;
    tick();
    bus.right_win = 1'b0;
    chk("r1_score", 32'(bus.right_score), 32'd1);
    chk("r1_hex",   32'(bus.hex_right),   32'h79);
    leave_hold();
    bus.right_win = 1'b1;
    tick();
    bus.right_win = 1'b0;
    chk("r2_score", 32'(bus.right_score), 32'd2);
    chk("r2_hex",   32'(bus.hex_right),   32'h24);
    chk("r2_mo",    32'(bus.match_over),  32'd0);
    leave_hold();
    bus.right_win = 1'b1;
    tick();
    bus.right_win = 1'b0;
    chk("r3_score",  32'(bus.right_score), 32'd3);
    chk("r3_hex",    32'(bus.hex_right),   32'h30);
    chk("r3_mo",     32'(bus.match_over),  32'd1);
    chk("r3_winner", 32'(bus.winner),      32'd2);
    chk("r3_rr",     32'(bus.round_reset), 32'd1);
    chk("r3_left",   32'(bus.left_score),  32'd1);

    // Extra wins after the match are ignored.
    bus.right_win = 1'b1;
    tick();
    bus.right_win = 1'b0;
    bus.left_win  = 1'b1;
    tick();
    bus.left_win  = 1'b0;
    chk("mo_right",  32'(bus.right_score), 32'd3);
    chk("mo_left",   32'(bus.left_score),  32'd1);
    chk("mo_winner", 32'(bus.winner),      32'd2);
    chk("mo_mo",     32'(bus.match_over),  32'd1);

    // start -> IDLE with cleared match.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("new_left",   32'(bus.left_score),  32'd0);
    chk("new_right",  32'(bus.right_score), 32'd0);
    chk("new_mo",     32'(bus.match_over),  32'd0);
    chk("new_winner", 32'(bus.winner),      32'd0);
    chk("new_rr",     32'(bus.round_reset), 32'd1);
    chk("new_hexr",   32'(bus.hex_right),   32'h40);

    // Reach left_score=2 and reset in the middle of the hold.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.left_win = 1'b1;
    tick();
    bus.left_win = 1'b0;
    leave_hold();
    bus.left_win = 1'b1;
    tick();
    bus.left_win = 1'b0;
    chk("pre_rst_left", 32'(bus.left_score), 32'd2);
    chk("pre_rst_hex",  32'(bus.hex_left),   32'h24);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_left",  32'(bus.left_score),  32'd0);
    chk("mid_rst_right", 32'(bus.right_score), 32'd0);
    chk("mid_rst_rr",    32'(bus.round_reset), 32'd1);
    chk("mid_rst_hexl",  32'(bus.hex_left),    32'h40);
    tick();
    chk("post_rst_idle_rr", 32'(bus.round_reset), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
